// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter slice.
package uart_arb_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int MAX_REQ     = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage : uart_arb_pkg

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, wrapping.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               any,
    output logic [IDX_W-1:0]   winner,
    output logic [NUM_REQ-1:0] winner_oh
);

    int               sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        any       = 1'b0;
        winner    = '0;
        winner_oh = '0;
        sum       = 0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = int'(last_owner) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = IDX_W'(sum);
            if (!any && req[idx]) begin
                any            = 1'b1;
                winner         = idx;
                winner_oh[idx] = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX byte port among NUM_REQ sources.
//  state | meaning
//  IDLE  | no owner; pick next requester round-robin from last_owner
//  XFER  | owner locked; bytes pass straight through until req_last or stall timeout
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int STALL_TIMEOUT = 4096
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_valid,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           stall_timeout
);

    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int CNT_W     = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam int TO_LAST_I = (STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    arb_state_t             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       last_owner_q, last_owner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stall_q, stall_d;

    logic                   pick_any;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_REQ-1:0]     pick_oh;

    logic [NUM_REQ-1:0][UART_BYTE_W-1:0] data_arr;
    logic                   own_valid;
    logic                   own_last;

    assign data_arr  = req_data;
    assign own_valid = req_valid[owner_q];
    assign own_last  = req_last[owner_q];

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req_valid),
        .last_owner (last_owner_q),
        .any        (pick_any),
        .winner     (pick_idx),
        .winner_oh  (pick_oh)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            stall_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            stall_q      <= stall_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        stall_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (own_valid) begin
                    // A byte on offer always resets the stall count.
                    cnt_d = '0;
                    if (tx_ready && own_last) begin
                        grant_d      = '0;
                        last_owner_d = owner_q;
                        state_d      = IDLE;
                    end
                end else if (STALL_TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    stall_d      = 1'b1;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (state_q == XFER) begin
            tx_valid  = own_valid;
            tx_data   = data_arr[owner_q];
            req_ready = grant_q & {NUM_REQ{tx_ready}};
        end
    end

    assign grant         = grant_q;
    assign stall_timeout = stall_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester drivers, byte monitor, directed scenarios.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [7:0]   data;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           stall_timeout;

    beat_t rq[N][$];
    exp_t  expq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int acc_cyc = 0;
    int n_stall = 0;
    int stall_cyc = 0;
    logic [N-1:0] stall_gnt;
    logic chk_rdy = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(N), .STALL_TIMEOUT(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .grant         (grant),
        .stall_timeout (stall_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input int r, input logic [7:0] d, input logic l, input logic exp_it);
        beat_t b;
        exp_t  e;
        b.data = d;
        b.last = l;
        rq[r].push_back(b);
        if (exp_it) begin
            e.gnt  = N'(1) << r;
            e.data = d;
            expq.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int ok;
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            #1;
            if (expq.size() == 0 && grant == '0 && rq[0].size() == 0 && rq[1].size() == 0 &&
                rq[2].size() == 0 && rq[3].size() == 0) begin
                ok = 1;
                break;
            end
        end
        check({name, "_drain"}, ok, 1);
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Requester drivers: hold a beat until the handshake seen mid-cycle, then advance.
    initial begin : drivers
        logic [N-1:0] hs;
        forever begin
            @(negedge clock);
            hs = req_valid & req_ready;
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = rq[i][0].data;
                    req_last[i]        = rq[i][0].last;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (tx_valid && tx_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("tx_data", {24'h0, tx_data}, {24'h0, e.data});
                    check("grant_at_byte", {28'h0, grant}, {28'h0, e.gnt});
                end
                n_acc++;
                acc_cyc = cyc + 1;
            end
            if (chk_rdy && grant == 4'b0010)
                check("req_ready1_tracks", {31'h0, req_ready[1]}, {31'h0, tx_ready});
            if (stall_timeout) begin
                n_stall++;
                stall_cyc = cyc;
                stall_gnt = grant;
            end
        end
    end

    initial begin : stimulus
        int base;
        int ok;
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;

        // 1 + 3: all requesters valid under reset, two rounds of single-byte packets
        for (int i = 0; i < N; i++) push_beat(i, 8'h10 + 8'(i), 1'b1, 1'b1);
        for (int i = 0; i < N; i++) push_beat(i, 8'h20 + 8'(i), 1'b1, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        check("rst_grant", {28'h0, grant}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_req_ready", {28'h0, req_ready}, 32'h0);
        check("rst_stall", {31'h0, stall_timeout}, 32'h0);
        @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1;
        check("first_grant", {28'h0, grant}, 32'h1);
        wait_drain("rr_rounds", 60);

        // 2: three-byte packet on req0 while req2 waits
        push_beat(0, 8'h41, 1'b0, 1'b1);
        push_beat(0, 8'h42, 1'b0, 1'b1);
        push_beat(0, 8'h43, 1'b1, 1'b1);
        push_beat(2, 8'h52, 1'b1, 1'b1);
        wait_drain("pkt_lock", 40);

        // 4: tx_ready toggling during a req1 packet
        chk_rdy = 1'b1;
        push_beat(1, 8'h11, 1'b0, 1'b1);
        push_beat(1, 8'h12, 1'b0, 1'b1);
        push_beat(1, 8'h13, 1'b0, 1'b1);
        push_beat(1, 8'h14, 1'b1, 1'b1);
        ok = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock);
            #1;
            tx_ready = ~tx_ready;
            if (expq.size() == 0 && grant == '0 && rq[1].size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("toggle_drain", ok, 1);
        tx_ready = 1'b1;
        chk_rdy  = 1'b0;

        // 5: req3 sends one byte then goes silent; req0 waits behind the lock
        base = n_acc;
        push_beat(3, 8'h77, 1'b0, 1'b1);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #2;
            if (n_acc > base) begin
                ok = 1;
                break;
            end
        end
        check("stall_byte_taken", ok, 1);
        push_beat(0, 8'h30, 1'b1, 1'b1);
        repeat (5) @(negedge clock);
        check("locked_grant", {28'h0, grant}, 32'h8);
        check("locked_tx_valid", {31'h0, tx_valid}, 32'h0);
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            #1;
            if (n_stall > 0) begin
                ok = 1;
                break;
            end
        end
        check("stall_seen", ok, 1);
        check("stall_delay", stall_cyc - acc_cyc, 16);
        check("stall_grant", {28'h0, stall_gnt}, 32'h0);
        wait_drain("after_stall", 20);

        // 6: reset after byte 2 of a 5-byte req1 packet
        push_beat(1, 8'h61, 1'b0, 1'b1);
        push_beat(1, 8'h62, 1'b0, 1'b1);
        push_beat(1, 8'h63, 1'b0, 1'b0);
        push_beat(1, 8'h64, 1'b0, 1'b0);
        push_beat(1, 8'h65, 1'b1, 1'b0);
        base = n_acc;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            #1;
            if (n_acc >= base + 2) begin
                ok = 1;
                break;
            end
        end
        check("two_bytes_before_rst", ok, 1);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("async_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("async_rst_grant", {28'h0, grant}, 32'h0);
        check("async_rst_req_ready", {28'h0, req_ready}, 32'h0);
        for (int i = 0; i < N; i++) rq[i].delete();
        expq.delete();
        push_beat(0, 8'hA0, 1'b1, 1'b1);
        push_beat(1, 8'h61, 1'b0, 1'b1);
        push_beat(1, 8'h62, 1'b0, 1'b1);
        push_beat(1, 8'h63, 1'b0, 1'b1);
        push_beat(1, 8'h64, 1'b0, 1'b1);
        push_beat(1, 8'h65, 1'b1, 1'b1);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_grant", {28'h0, grant}, 32'h1);
        wait_drain("restart", 40);

        check("stall_pulse_count", n_stall, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
